four_byte_tx: RTL and testbench

UART transmit path for the host link: accepts one 32-bit word with a data-valid strobe and serializes it as four 8N1 UART bytes on a single serial line, most-significant byte first. It is the transmit-side counterpart of the four-byte receive path that feeds frequency selection. It returns status words, such as the active frequency code or divider, to the Python host. It contains the complete bit-timing engine; no external UART transmitter is used.

---
 rtl/four_byte_tx.sv | 131 +++++++++++++
 tb/tb_four_byte_tx.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/four_byte_tx.sv
// UART transmitter for one 32-bit word as four 8N1 bytes, MSB byte first, LSB bit first.
// All outputs are registered; the bit-timing counter is internal.
module four_byte_tx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic        clk_100MHz,
    input  logic        RSTN,
    input  logic [31:0] i_Tx_Four_Bytes,
    input  logic        i_Tx_DV,
    output logic        o_Tx_Serial,
    output logic        o_Tx_Active,
    output logic        o_Tx_Done
);

    localparam logic [15:0] CntMax = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StDone
    } state_t;

    state_t      state;
    logic [15:0] clk_cnt;
    logic [2:0]  bit_idx;
    logic [1:0]  byte_idx;
    logic [31:0] shift_word;
    logic [7:0]  cur_byte;

    always_comb begin
        cur_byte = shift_word[31:24];
        case (byte_idx)
            2'd0:    cur_byte = shift_word[31:24];
            2'd1:    cur_byte = shift_word[23:16];
            2'd2:    cur_byte = shift_word[15:8];
            default: cur_byte = shift_word[7:0];
        endcase
    end

    // Outputs are set on the edge that enters each bit, so they line up with the state.
    always_ff @(posedge clk_100MHz or negedge RSTN) begin
        if (!RSTN) begin
            state       <= StIdle;
            clk_cnt     <= 16'd0;
            bit_idx     <= 3'd0;
            byte_idx    <= 2'd0;
            shift_word  <= 32'd0;
            o_Tx_Serial <= 1'b1;
            o_Tx_Active <= 1'b0;
            o_Tx_Done   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    o_Tx_Done   <= 1'b0;
                    if (i_Tx_DV) begin
                        shift_word  <= i_Tx_Four_Bytes;
                        byte_idx    <= 2'd0;
                        bit_idx     <= 3'd0;
                        clk_cnt     <= 16'd0;
                        o_Tx_Serial <= 1'b0;
                        o_Tx_Active <= 1'b1;
                        state       <= StStart;
                    end
                end

                StStart: begin
                    if (clk_cnt == CntMax) begin
                        clk_cnt     <= 16'd0;
                        bit_idx     <= 3'd0;
                        o_Tx_Serial <= cur_byte[0];
                        state       <= StData;
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end

                StData: begin
                    if (clk_cnt == CntMax) begin
                        clk_cnt <= 16'd0;
                        if (bit_idx == 3'd7) begin
                            o_Tx_Serial <= 1'b1;
                            state       <= StStop;
                        end else begin
                            bit_idx     <= bit_idx + 3'd1;
                            o_Tx_Serial <= cur_byte[bit_idx + 3'd1];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end

                StStop: begin
                    if (clk_cnt == CntMax) begin
                        clk_cnt <= 16'd0;
                        if (byte_idx == 2'd3) begin
                            o_Tx_Serial <= 1'b1;
                            o_Tx_Active <= 1'b0;
                            o_Tx_Done   <= 1'b1;
                            state       <= StDone;
                        end else begin
                            byte_idx    <= byte_idx + 2'd1;
                            o_Tx_Serial <= 1'b0;
                            state       <= StStart;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 16'd1;
                    end
                end

                StDone: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    o_Tx_Done   <= 1'b0;
                    state       <= StIdle;
                end

                default: begin
                    o_Tx_Serial <= 1'b1;
                    o_Tx_Active <= 1'b0;
                    o_Tx_Done   <= 1'b0;
                    state       <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_four_byte_tx.sv
// Directed bench for four_byte_tx: captures the line per cycle and compares it with a bit-level model.
module tb_four_byte_tx;

    localparam int CPB = 4;

    logic        clk_100MHz;
    logic        RSTN;
    logic [31:0] i_Tx_Four_Bytes;
    logic        i_Tx_DV;
    logic        o_Tx_Serial;
    logic        o_Tx_Active;
    logic        o_Tx_Done;

    int total;
    int bad;

    four_byte_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_100MHz      (clk_100MHz),
        .RSTN            (RSTN),
        .i_Tx_Four_Bytes (i_Tx_Four_Bytes),
        .i_Tx_DV         (i_Tx_DV),
        .o_Tx_Serial     (o_Tx_Serial),
        .o_Tx_Active     (o_Tx_Active),
        .o_Tx_Done       (o_Tx_Done)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected line level in cycle i (1 = first cycle after the accept edge).
    function automatic logic model_ser(input int i, input logic [31:0] w);
        int p, b, pos;
        logic [7:0] bt;
        if (i < 1 || i > 40 * CPB) return 1'b1;
        p   = (i - 1) / CPB;
        b   = p / 10;
        pos = p % 10;
        bt  = 8'(w >> (8 * (3 - b)));
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return bt[pos - 1];
    endfunction

    // Request at the current negedge, record n cycles, optionally pulse a busy request.
    task automatic run_frame(input string tag, input logic [31:0] word, input logic [31:0] exp_word,
                             input int n, input int inj1, input int inj2);
        logic ser [0:255];
        logic act [0:255];
        logic dn  [0:255];
        int act_cnt, first_act, done_cnt, done_at, wave_err;
        logic [7:0] dec;
        i_Tx_Four_Bytes = word;
        i_Tx_DV         = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk_100MHz);
            ser[i] = o_Tx_Serial;
            act[i] = o_Tx_Active;
            dn[i]  = o_Tx_Done;
            if (i == inj1 || i == inj2) begin
                i_Tx_DV         = 1'b1;
                i_Tx_Four_Bytes = 32'h2222_2222;
            end else begin
                i_Tx_DV = 1'b0;
            end
        end
        act_cnt = 0; first_act = -1; done_cnt = 0; done_at = -1; wave_err = 0;
        for (int i = 1; i <= n; i++) begin
            if (act[i] === 1'b1) begin
                act_cnt++;
                if (first_act < 0) first_act = i;
            end
            if (dn[i] === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
            if (ser[i] !== model_ser(i, exp_word)) wave_err++;
            if (act[i] !== ((i >= 1 && i <= 40 * CPB) ? 1'b1 : 1'b0)) wave_err++;
        end
        check({tag, " active_cycles"}, act_cnt, 40 * CPB);
        check({tag, " first_active"}, first_act, 1);
        check({tag, " done_count"}, done_cnt, 1);
        check({tag, " done_cycle"}, done_at, 40 * CPB + 1);
        check({tag, " waveform_errs"}, wave_err, 0);
        for (int b = 0; b < 4; b++) begin
            for (int j = 0; j < 8; j++) dec[j] = ser[1 + (b * 10 + 1 + j) * CPB + CPB / 2];
            check($sformatf("%s byte%0d", tag, b), {24'd0, dec}, {24'd0, 8'(exp_word >> (8 * (3 - b)))});
        end
    endtask

    initial begin
        int idle_err;
        total = 0;
        bad   = 0;
        RSTN            = 1'b0;
        i_Tx_DV         = 1'b1;
        i_Tx_Four_Bytes = 32'hFFFF_0000;

        // Reset held with a pending request: outputs stay at reset values.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_100MHz);
            check("reset_outputs", {29'd0, o_Tx_Serial, o_Tx_Active, o_Tx_Done}, 32'b100);
        end
        i_Tx_DV = 1'b0;
        RSTN    = 1'b1;
        idle_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_100MHz);
            if ({o_Tx_Serial, o_Tx_Active, o_Tx_Done} !== 3'b100) idle_err++;
        end
        check("idle_after_release", idle_err, 0);

        run_frame("single", 32'h0000_0002, 32'h0000_0002, 170, -1, -1);
        run_frame("order", 32'hA5C3_0F81, 32'hA5C3_0F81, 170, -1, -1);
        // Request during byte 1 and in the DONE cycle must both be dropped.
        run_frame("busy", 32'h1111_1111, 32'h1111_1111, 175, 50, 40 * CPB + 1);
        // Window ends in the first idle cycle; next request lands right there.
        run_frame("b2b_first", 32'h8000_0001, 32'h8000_0001, 40 * CPB + 2, -1, -1);
        run_frame("b2b_second", 32'h0000_0003, 32'h0000_0003, 170, -1, -1);

        // Reset in byte 2 data while the line is low (0F bit 4).
        i_Tx_Four_Bytes = 32'hA5C3_0F81;
        i_Tx_DV         = 1'b1;
        for (int i = 1; i <= 102; i++) begin
            @(negedge clk_100MHz);
            i_Tx_DV = 1'b0;
        end
        check("midframe_line_low", {31'd0, o_Tx_Serial}, 32'd0);
        check("midframe_active", {31'd0, o_Tx_Active}, 32'd1);
        RSTN = 1'b0;
        #1;
        check("async_reset_outputs", {29'd0, o_Tx_Serial, o_Tx_Active, o_Tx_Done}, 32'b100);
        repeat (3) @(negedge clk_100MHz);
        RSTN = 1'b1;
        idle_err = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_100MHz);
            if ({o_Tx_Serial, o_Tx_Active, o_Tx_Done} !== 3'b100) idle_err++;
        end
        check("no_resume_after_reset", idle_err, 0);

        run_frame("recover", 32'h5A00_FF3C, 32'h5A00_FF3C, 170, -1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
